// File: rtl/apb_requester.sv
// apb_requester: APB initiator that drains a small command FIFO into
// SETUP/ACCESS transfers and returns one response per command, in order.
// Read data is taken one cycle after ACCESS because the responder registers
// PRDATA on the ACCESS clock edge.
module apb_requester #(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AMBA_WORD-1:0]       cmd_wdata,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    input  logic [AMBA_WORD-1:0]       PRDATA,
    output logic                       rsp_valid,
    output logic                       rsp_write,
    output logic [AMBA_WORD-1:0]       rsp_rdata,
    output logic                       busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 1 + AMBA_ADDR_WIDTH + AMBA_WORD;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SETUP   = 2'd1;
    localparam logic [1:0] ACCESS  = 2'd2;
    localparam logic [1:0] CAPTURE = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          fifo_nonempty;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    assign fifo_nonempty = (count != '0);
    assign cmd_ready     = (count < (PW+1)'(FIFO_DEPTH));
    assign push          = cmd_valid & cmd_ready;
    assign head          = mem[rd_ptr];

    // A new transfer starts whenever the FSM is free to issue and the FIFO has work
    assign pop = fifo_nonempty &
                 ((state == IDLE) || (state == CAPTURE) || ((state == ACCESS) && PWRITE));

    assign PSEL    = (state == SETUP) || (state == ACCESS);
    assign PENABLE = (state == ACCESS);
    assign busy    = (state != IDLE) || fifo_nonempty;

    // Command storage; contents need no reset since only counted entries are read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + (PW+1)'(1);
            else if (!push && pop) count <= count - (PW+1)'(1);
        end
    end

    // Next-state decode for the APB phase sequencer
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = fifo_nonempty ? SETUP : IDLE;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  state_nxt = PWRITE ? (fifo_nonempty ? SETUP : IDLE) : CAPTURE;
            CAPTURE: state_nxt = fifo_nonempty ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Phase register, APB address/data holding registers and response generation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= 1'b0;
            if (pop) begin
                {PWRITE, PADDR, PWDATA} <= head;
            end
            if ((state == ACCESS) && PWRITE) begin
                rsp_valid <= 1'b1;
                rsp_write <= 1'b1;
            end
            if (state == CAPTURE) begin
                rsp_valid <= 1'b1;
                rsp_write <= 1'b0;
                rsp_rdata <= PRDATA;
            end
        end
    end

endmodule

// File: tb/tb_apb_requester.sv
// tb_apb_requester: drives randomized and directed command streams into
// apb_requester with a simple registered APB responder attached, and checks
// every cycle against a transaction-level schedule model.
module tb_apb_requester;

    localparam int AW    = 20;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          rsp_valid, rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic          busy;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned edge_n      = 0;
    int unsigned saw_full    = 0;

    apb_requester #(.AMBA_ADDR_WIDTH(AW), .AMBA_WORD(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Edge counter: at the negedge following edge k it reads k
    always @(posedge clk) edge_n <= edge_n + 1;

    // Register responder: four words selected by addr[3:2], PRDATA registered on ACCESS
    logic [DW-1:0] resp_regs [4] = '{default: '0};
    logic [DW-1:0] prdata_r = '0;
    assign PRDATA = prdata_r;
    always @(posedge clk) begin
        if (PSEL && PENABLE) begin
            if (PWRITE) resp_regs[PADDR[3:2]] <= PWDATA;
            else        prdata_r <= resp_regs[PADDR[3:2]];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: each accepted command gets its issue edge and
    // completion edge from the throughput rules (write 2 cycles, read 3).
    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int unsigned   acc;
        int unsigned   p;
        int unsigned   r;
    } cmd_t;

    cmd_t          mq[$];
    int unsigned   next_free = 0;
    logic [DW-1:0] mdl_regs [4] = '{default: '0};
    logic [AW-1:0] exp_paddr  = '0;
    logic [DW-1:0] exp_pwdata = '0;
    logic          exp_pwrite = 1'b0;
    logic [DW-1:0] exp_rdata  = '0;

    always @(negedge clk) begin
        cmd_t        e;
        int unsigned n;
        int unsigned cnt;
        logic        ep, en, ev;
        n = edge_n;
        if (rst) begin
            mq.delete();
            next_free  = 0;
            exp_paddr  = '0;
            exp_pwdata = '0;
            exp_pwrite = 1'b0;
            exp_rdata  = '0;
            check("rst_psel", PSEL, 0);
            check("rst_penable", PENABLE, 0);
            check("rst_pwrite", PWRITE, 0);
            check("rst_paddr", PADDR, 0);
            check("rst_pwdata", PWDATA, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_write", rsp_write, 0);
            check("rst_rsp_rdata", rsp_rdata, 0);
            check("rst_cmd_ready", cmd_ready, 1);
            check("rst_busy", busy, 0);
        end else begin
            ev = 1'b0;
            if (mq.size() != 0 && mq[0].r == n) begin
                e  = mq.pop_front();
                ev = 1'b1;
                if (e.w) mdl_regs[e.a[3:2]] = e.d;
                else     exp_rdata = mdl_regs[e.a[3:2]];
                check("rsp_write", rsp_write, e.w);
            end
            check("rsp_valid", rsp_valid, ev);
            check("rsp_rdata", rsp_rdata, exp_rdata);
            ep = 1'b0; en = 1'b0; cnt = 0;
            foreach (mq[i]) begin
                if (mq[i].p == n) begin
                    exp_paddr  = mq[i].a;
                    exp_pwdata = mq[i].d;
                    exp_pwrite = mq[i].w;
                end
                if (mq[i].p == n || mq[i].p + 1 == n) ep = 1'b1;
                if (mq[i].p + 1 == n) en = 1'b1;
                if (mq[i].p > n) cnt++;
            end
            check("psel", PSEL, ep);
            check("penable", PENABLE, en);
            check("paddr", PADDR, exp_paddr);
            check("pwdata", PWDATA, exp_pwdata);
            check("pwrite", PWRITE, exp_pwrite);
            check("cmd_ready", cmd_ready, (cnt < DEPTH) ? 1 : 0);
            check("busy", busy, (mq.size() != 0) ? 1 : 0);
            if (!cmd_ready) saw_full++;
            if (cmd_valid && cmd_ready) begin
                e.w   = cmd_write;
                e.a   = cmd_addr;
                e.d   = cmd_wdata;
                e.acc = n + 1;
                e.p   = (e.acc + 1 > next_free) ? e.acc + 1 : next_free;
                e.r   = e.w ? e.p + 2 : e.p + 3;
                next_free = e.r;
                mq.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one command and hold it until accepted (bounded)
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int unsigned k;
        logic        acc;
        k = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        do begin
            acc = cmd_ready;
            tick();
            k++;
        end while (!acc && k < 64);
        cmd_valid = 1'b0;
        if (!acc) check("send_timeout", 0, 1);
    endtask

    initial begin
        int unsigned k;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Single write: SETUP after E1, ACCESS E2-E3, response after E3
        send(1'b1, 20'h00000, 32'hA5A5_0001);
        tick();
        check("w_setup_psel", PSEL, 1);
        check("w_setup_penable", PENABLE, 0);
        tick();
        check("w_access_penable", PENABLE, 1);
        check("w_access_paddr", PADDR, 20'h00000);
        check("w_access_pwdata", PWDATA, 32'hA5A5_0001);
        tick();
        check("w_rsp_valid", rsp_valid, 1);
        check("w_rsp_write", rsp_write, 1);
        tick();
        check("w_rsp_pulse", rsp_valid, 0);
        check("w_ctrl_reg", resp_regs[0], 32'hA5A5_0001);
        repeat (3) tick();

        // Read-back of a written register
        send(1'b1, 20'h00008, 32'h0000_0020);
        send(1'b0, 20'h00008, 32'hDEAD_BEEF);
        repeat (10) tick();

        // Back-to-back writes then reads
        for (int i = 0; i < 4; i++) send(1'b1, AW'(4 * i), $urandom);
        send(1'b0, 20'h0000C, $urandom);
        send(1'b0, 20'h00004, $urandom);
        repeat (20) tick();

        // Full FIFO: first command in flight, then a burst that overruns it
        send(1'b0, 20'h00004, $urandom);
        k = 0;
        while (!PENABLE && k < 20) begin tick(); k++; end
        check("full_wait_access", PENABLE, 1);
        for (int i = 0; i < 8; i++) send(1'b0, AW'(4 * (i % 4)), $urandom);
        check("fifo_reached_full", (saw_full != 0) ? 1 : 0, 1);
        repeat (30) tick();

        // Reset while ACCESS is active with two commands queued
        send(1'b1, 20'h00000, 32'h1111_1111);
        send(1'b1, 20'h00004, 32'h2222_2222);
        send(1'b1, 20'h00008, 32'h3333_3333);
        k = 0;
        while (!PENABLE && k < 20) begin tick(); k++; end
        check("mid_access", PENABLE, 1);
        rst = 1'b1;
        #1;
        check("async_psel", PSEL, 0);
        check("async_penable", PENABLE, 0);
        check("async_rsp_valid", rsp_valid, 0);
        check("async_busy", busy, 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check("abandoned_reg0", resp_regs[0], mdl_regs[0]);
        check("abandoned_reg1", resp_regs[1], mdl_regs[1]);

        // Randomized command stream with random gaps
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            send(1'($urandom_range(0, 1)), AW'($urandom), $urandom);
        end

        // Idle hold: everything drains, holding registers stay put
        repeat (30) tick();
        check("drain_empty", mq.size(), 0);
        check("idle_busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            check("final_reg", resp_regs[i], mdl_regs[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apb_requester.md
# apb_requester

APB initiator that turns a queued stream of simple register commands into APB SETUP/ACCESS transfers toward the block's APB register responder, i.e. the CTRL/DATA_IN/CODEWORD_WIDTH/NOISE register file. It buffers commands in a small FIFO, sequences PSEL/PENABLE, and returns one response per command. Read data is captured one cycle after ACCESS because the responder registers PRDATA on the ACCESS clock edge. It sits in the encoder/decoder testbench and CPU-model path as the driver of the register interface.

## Interface
- AMBA_ADDR_WIDTH, 20, PADDR / cmd_addr width
- AMBA_WORD, 32, data width of PWDATA, PRDATA, cmd_wdata, rsp_rdata
- FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept; high iff FIFO count < FIFO_DEPTH
- cmd_write  in  1  1 = APB write, 0 = APB read
- cmd_addr  in  AMBA_ADDR_WIDTH  target address; register select is addr[3:2]
- cmd_wdata  in  AMBA_WORD  write data; ignored for reads
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  AMBA_ADDR_WIDTH  APB address
- PWDATA  out  AMBA_WORD  APB write data
- PRDATA  in  AMBA_WORD  APB read data; registered by the responder
- rsp_valid  out  1  one-cycle pulse per completed command
- rsp_write  out  1  type of the completed command
- rsp_rdata  out  AMBA_WORD  read data; updated only on read completions
- busy  out  1  FIFO non-empty or FSM not IDLE

## Operation
- Push on cmd_valid & cmd_ready. cmd_ready depends only on the count. When full, cmd_ready stays low even in a pop cycle.
- FSM states:
  - IDLE: PSEL = 0, PENABLE = 0.
  - SETUP: PSEL = 1, PENABLE = 0.
  - ACCESS: PSEL = 1, PENABLE = 1.
  - CAPTURE: PSEL = 0, PENABLE = 0.
- Transitions:
  - IDLE -> SETUP when FIFO non-empty. Pop the head and register it into PADDR/PWDATA/PWRITE at the same edge.
  - SETUP -> ACCESS unconditionally. The responder has no PREADY, so every ACCESS lasts exactly one cycle.
  - ACCESS, write: rsp_valid <= 1, rsp_write <= 1. Next state is SETUP with a pop if the FIFO is non-empty, else IDLE.
  - ACCESS, read: -> CAPTURE.
  - CAPTURE: rsp_rdata <= PRDATA, rsp_valid <= 1, rsp_write <= 0. Next state is SETUP with a pop if the FIFO is non-empty, else IDLE.
- PADDR/PWDATA/PWRITE change only on a pop and otherwise hold their last values. PWDATA is loaded for reads too, with the don't-care cmd_wdata.
- rsp_valid is high for exactly one cycle per command. Responses come out in command order. There is no response backpressure.
- FIFO pointers wrap modulo FIFO_DEPTH. A push and a pop in the same cycle keep the count unchanged. A push to an empty FIFO is not visible to the FSM until the following cycle; there is no bypass.
- busy = (state != IDLE) | (count != 0).
- Reset, including mid-transfer: FIFO flushed, FSM -> IDLE. An abandoned transfer produces no response.

## Timing
- Reset values: PSEL = 0, PENABLE = 0, PWRITE = 0, PADDR = 0, PWDATA = 0, rsp_valid = 0, rsp_write = 0, rsp_rdata = 0, cmd_ready = 1, busy = 0.
- Edge numbering: command accepted at edge E0. IDLE pops at E1, SETUP is cycle E1-E2, ACCESS is cycle E2-E3.
- Write: rsp_valid high during E3-E4. Latency is 3 cycles from acceptance.
- Read: CAPTURE is E3-E4, rsp_valid and rsp_rdata appear during E4-E5. Latency is 4 cycles.
- Throughput with a non-empty FIFO:
  - Back-to-back writes: one every 2 cycles; PSEL stays high continuously.
  - Reads: one every 3 cycles.

## Test plan
- Write: cmd (write, 0x00, 0xA5A5_0001) at E0 -> PSEL rises after E1, PENABLE high E2-E3 with PADDR = 0x00 and PWDATA = 0xA5A5_0001; rsp_valid = 1 and rsp_write = 1 for one cycle after E3; responder CTRL = 0xA5A5_0001.
- Read-back: write 0x0000_0020 to 0x08, then read 0x08 -> read rsp_valid with rsp_rdata = 0x0000_0020 and rsp_write = 0; PSEL low during CAPTURE.
- Back-to-back: queue writes to 0x00, 0x04, 0x08, 0x0C, then reads of 0x0C and 0x04 -> PSEL high continuously across the four writes; write responses 2 cycles apart; reads return the written values in order.
- Full FIFO: hold an initial command in ACCESS, offer 5 more -> FIFO accepts 4, then cmd_ready = 0; it rises the cycle after the next pop; no command lost or duplicated.
- Reset mid-ACCESS: assert rst while PENABLE = 1 with 2 commands queued -> PSEL, PENABLE and rsp_valid go low immediately (asynchronously); busy = 0; no response is produced for the in-flight or queued commands.
- Idle hold: after the last completion, no commands -> PADDR and PWDATA hold their values, busy = 0, rsp_rdata unchanged by later writes.
